// File: rtl/sntc_ldpc_cword_loader.sv
// LDPC codeword loader: assembles W-bit beats into an NN-bit hard-decision
// word, presents it to an external syndrome stage, waits SYN_LAT cycles,
// then reports syndrome weight / validity until the result is taken.
module sntc_ldpc_cword_loader #(
  parameter  int NN      = 'h000d0,
  parameter  int MM      = 'h000a8,
  parameter  int W       = 16,
  parameter  int SYN_LAT = 1,
  localparam int NBEATS  = (NN + W - 1) / W,
  localparam int SUM_MM  = $clog2(MM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [W-1:0]      in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [NN-1:0]     y_nr_out,
  output logic              syn_clr,
  input  logic [MM-1:0]     syn_nr_in,
  input  logic              valid_cword_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_ok,
  output logic [SUM_MM-1:0] res_weight,
  output logic              res_len_err
);

  localparam int CNT_W = $clog2(NBEATS + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EVAL, S_REPORT} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    beat_cnt;
  logic [3:0]          lat_cnt;
  logic                lenerr;
  logic                xfer;
  logic                last_beat;
  logic                lat_done;
  logic [NN-1:0]       wr_mask;
  logic [NN-1:0]       wr_data;
  logic [SUM_MM-1:0]   pop;

  assign xfer      = in_valid && in_ready;
  assign last_beat = (beat_cnt == CNT_W'(NBEATS - 1));
  assign lat_done  = (lat_cnt == 4'(SYN_LAT - 1));

  // Select the codeword bits owned by the current beat; bits past NN never exist
  always_comb begin
    wr_mask = '0;
    wr_data = '0;
    for (int i = 0; i < NN; i++) begin
      wr_data[i] = in_data[i % W];
      wr_mask[i] = (beat_cnt == CNT_W'(i / W));
    end
  end

  // Syndrome population count, range 0..MM
  always_comb begin
    pop = '0;
    for (int i = 0; i < MM; i++) pop = pop + SUM_MM'(syn_nr_in[i]);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: the final beat always ends loading; an early in_last aborts
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_LOAD: begin
        if (xfer) begin
          if (last_beat)    state_nxt = S_EVAL;
          else if (in_last) state_nxt = S_IDLE;
          else              state_nxt = S_LOAD;
        end
      end
      S_EVAL:   if (lat_done)  state_nxt = S_REPORT;
      S_REPORT: if (res_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs: accept beats only while loading; clear the syndrome stage on a frame's first beat
  always_comb begin
    in_ready  = ~rst && (state == S_IDLE || state == S_LOAD);
    syn_clr   = xfer && (state == S_IDLE);
    res_valid = (state == S_REPORT);
  end

  // Datapath: beat assembly, latency count, result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt    <= '0;
      lat_cnt     <= '0;
      lenerr      <= 1'b0;
      y_nr_out    <= '0;
      res_ok      <= 1'b0;
      res_weight  <= '0;
      res_len_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_LOAD: begin
          if (xfer) begin
            y_nr_out <= (y_nr_out & ~wr_mask) | (wr_data & wr_mask);
            if (last_beat) begin
              beat_cnt <= '0;
              lat_cnt  <= '0;
              lenerr   <= ~in_last;
            end else if (in_last) begin
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        S_EVAL: begin
          if (lat_done) begin
            res_weight  <= pop;
            res_ok      <= valid_cword_in && (pop == '0) && ~lenerr;
            res_len_err <= lenerr;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sntc_ldpc_cword_loader.sv
// Directed bench with a scoreboard: frames push expected results, a negedge
// monitor pops and compares at each result handshake.
module tb_sntc_ldpc_cword_loader;
  localparam int NN = 208, MM = 168, W = 16, SYN_LAT = 1, NBEATS = 13, SUM_MM = 8;

  logic              clk = 1'b0, rst = 1'b1;
  logic              in_valid = 1'b0, in_last = 1'b0, res_ready = 1'b1, valid_cword_in = 1'b0;
  logic [W-1:0]      in_data = '0;
  logic [MM-1:0]     syn_nr_in = '0;
  logic              in_ready, syn_clr, res_valid, res_ok, res_len_err;
  logic [NN-1:0]     y_nr_out;
  logic [SUM_MM-1:0] res_weight;

  typedef struct packed {
    logic              ok;
    logic [SUM_MM-1:0] wt;
    logic              le;
    logic [NN-1:0]     y;
  } exp_t;

  exp_t q[$];
  int errors = 0, checks = 0, beats_seen = 0, clr_seen = 0;

  always #5 clk = ~clk;

  sntc_ldpc_cword_loader #(.NN(NN), .MM(MM), .W(W), .SYN_LAT(SYN_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .y_nr_out(y_nr_out), .syn_clr(syn_clr), .syn_nr_in(syn_nr_in),
    .valid_cword_in(valid_cword_in), .res_valid(res_valid), .res_ready(res_ready),
    .res_ok(res_ok), .res_weight(res_weight), .res_len_err(res_len_err)
  );

  task automatic chk(input string name, input logic [NN-1:0] act, input logic [NN-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: beat/clear counts, backpressure, hold stability, scoreboard pops
  logic [SUM_MM+1:0] held;
  logic              pend = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && in_valid && in_ready) beats_seen++;
    if (syn_clr) clr_seen++;
    if (res_valid) chk("in_ready_during_report", in_ready, 0);
    if (pend && !rst) begin
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_values", {res_ok, res_weight, res_len_err}, held);
    end
    pend = res_valid && !res_ready && !rst;
    held = {res_ok, res_weight, res_len_err};
    if (res_valid && res_ready && !rst) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got res_valid=1 want no result");
      end else begin
        e = q.pop_front();
        chk("res_ok", res_ok, e.ok);
        chk("res_weight", res_weight, e.wt);
        chk("res_len_err", res_len_err, e.le);
        chk("y_nr_out", y_nr_out, e.y);
      end
    end
  end

  function automatic logic [W-1:0] beat_val(input int k, input logic [W-1:0] seed, input logic [W-1:0] step);
    logic [W-1:0] v;
    v = W'(k * step);
    if (k == 0) v = v ^ seed;
    return v;
  endfunction

  function automatic logic [NN-1:0] build_y(input logic [W-1:0] seed, input logic [W-1:0] step);
    logic [NBEATS*W-1:0] t;
    t = '0;
    for (int k = 0; k < NBEATS; k++) t[k*W +: W] = beat_val(k, seed, step);
    return t[NN-1:0];
  endfunction

  task automatic send_beat(input logic [W-1:0] d, input logic last);
    int   t;
    logic acc;
    t = 0; acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!acc) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      t++;
      if (t > 200) begin
        checks++; errors++;
        $display("FAIL beat_timeout: got no in_ready want accept within 200 cycles");
        acc = 1'b1;
      end
    end
  endtask

  task automatic send_frame(input int nb, input int last_at, input logic [W-1:0] seed,
                            input logic [W-1:0] step, input logic keep);
    for (int k = 0; k < nb; k++) send_beat(beat_val(k, seed, step), k == last_at);
    if (!keep) begin in_valid = 1'b0; in_last = 1'b0; end
  endtask

  task automatic push(input logic ok, input logic [SUM_MM-1:0] wt, input logic le, input logic [NN-1:0] y);
    exp_t e;
    e.ok = ok; e.wt = wt; e.le = le; e.y = y;
    q.push_back(e);
  endtask

  task automatic drain;
    int t;
    t = 0;
    while ((q.size() != 0 || res_valid) && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_syn_clr"}, syn_clr, 0);
    chk({tag, "_y"}, y_nr_out, 0);
    chk({tag, "_res_ok"}, res_ok, 0);
    chk({tag, "_res_weight"}, res_weight, 0);
    chk({tag, "_res_len_err"}, res_len_err, 0);
  endtask

  initial begin
    int b0, c0, t;
    // Reset state
    @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); chk("por_in_ready_after", in_ready, 1);
    @(posedge clk); #1;

    // All-zero codeword, latency of two cycles from last beat to res_valid
    syn_nr_in = '0; valid_cword_in = 1'b1;
    push(1'b1, 8'd0, 1'b0, '0);
    send_frame(NBEATS, NBEATS-1, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk); chk("lat_eval_no_valid", res_valid, 0);
    @(negedge clk); chk("lat_report_valid", res_valid, 1);
    drain();

    // Single-bit error, five syndrome ones, result held under backpressure
    syn_nr_in = 168'h1F; valid_cword_in = 1'b0; res_ready = 1'b0;
    push(1'b0, 8'd5, 1'b0, build_y(16'h0001, 16'h0000));
    send_frame(NBEATS, NBEATS-1, 16'h0001, 16'h0000, 1'b0);
    t = 0;
    while (!res_valid && t < 50) begin @(posedge clk); #1; t++; end
    chk("bit0_res_valid_seen", res_valid, 1);
    repeat (10) begin @(posedge clk); #1; end
    res_ready = 1'b1;
    drain();

    // Early in_last on beat 4 aborts; then a clean frame
    syn_nr_in = '0; valid_cword_in = 1'b1;
    send_frame(5, 4, 16'hBEEF, 16'h1111, 1'b0);
    repeat (4) @(negedge clk);
    chk("abort_no_result", res_valid, 0);
    chk("abort_idle_ready", in_ready, 1);
    @(posedge clk); #1;
    push(1'b1, 8'd0, 1'b0, build_y(16'hA5A5, 16'h1357));
    send_frame(NBEATS, NBEATS-1, 16'hA5A5, 16'h1357, 1'b0);
    drain();

    // Frame without in_last: length error
    push(1'b0, 8'd0, 1'b1, build_y(16'h0F0F, 16'h2468));
    send_frame(NBEATS, -1, 16'h0F0F, 16'h2468, 1'b0);
    drain();

    // Back-to-back frames with in_valid held high throughout
    b0 = beats_seen; c0 = clr_seen;
    syn_nr_in = 168'h3; valid_cword_in = 1'b0;
    push(1'b0, 8'd2, 1'b0, build_y(16'h1234, 16'h0101));
    push(1'b0, 8'd2, 1'b0, build_y(16'h4321, 16'h0707));
    send_frame(NBEATS, NBEATS-1, 16'h1234, 16'h0101, 1'b1);
    send_frame(NBEATS, NBEATS-1, 16'h4321, 16'h0707, 1'b0);
    drain();
    chk("b2b_beats", beats_seen - b0, 2*NBEATS);
    chk("b2b_syn_clr", clr_seen - c0, 2);

    // Reset at beat 7 discards the frame
    syn_nr_in = '0; valid_cword_in = 1'b1;
    send_frame(7, -1, 16'hCAFE, 16'h0303, 1'b0);
    rst = 1'b1;
    @(negedge clk); chk_reset_outputs("mid");
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); chk("mid_in_ready_after", in_ready, 1);
    @(posedge clk); #1;
    // All-ones syndrome after reset
    syn_nr_in = '1; valid_cword_in = 1'b0;
    push(1'b0, 8'd168, 1'b0, build_y(16'h5A5A, 16'h0F0F));
    send_frame(NBEATS, NBEATS-1, 16'h5A5A, 16'h0F0F, 1'b0);
    drain();

    // Reset while a result is pending discards it
    res_ready = 1'b0; syn_nr_in = '0; valid_cword_in = 1'b1;
    send_frame(NBEATS, NBEATS-1, 16'h7777, 16'h0001, 1'b0);
    t = 0;
    while (!res_valid && t < 50) begin @(posedge clk); #1; t++; end
    chk("pend_res_valid_seen", res_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; res_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("pend_discarded", res_valid, 0);
    chk("scoreboard_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
